transpose_memory_ctrl: RTL and testbench

Sequencing controller for the skewed transpose memory banks behind the matrix-transpose datapath. Accepts NUM_PE input rows via a valid/ready handshake and drives the bank write enable, write address and write rotation. Once a tile is complete, it issues NUM_PE column reads with per-bank skewed addresses. Two tile buffers (ping-pong halves of each bank) let filling of tile n+1 overlap draining of tile n.

---
 rtl/mtm_pkg.sv | 21 ++
 rtl/transpose_memory_ctrl_if.sv | 28 ++
 rtl/mtm_skew_addr_gen.sv | 21 ++
 rtl/transpose_memory_ctrl.sv | 95 +++++++++
 tb/tb_transpose_memory_ctrl.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/mtm_pkg.sv
// Shared types and address helpers for the transpose memory controller.
package mtm_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  // Bank address = {buffer half, row index}
  function automatic int bank_addr_width(input int num_pe);
    return $clog2(num_pe) + 1;
  endfunction

  // Row held by a bank for a given column; num_pe is a power of two so the mask is the wrap.
  function automatic int unsigned skew_row(input int unsigned bank,
                                           input int unsigned col,
                                           input int unsigned num_pe);
    return (bank - col) & (num_pe - 1);
  endfunction

endpackage

// File: rtl/transpose_memory_ctrl_if.sv
// Handshake and bank-control bundle between the transpose controller and its datapath.
interface transpose_memory_ctrl_if #(
  parameter int NUM_MG     = 8,
  parameter int NUM_PE     = 8,
  parameter int ADDR_WIDTH = $clog2(NUM_PE)
);
  logic                               in_val;
  logic                               in_rdy;
  logic                               wen;
  logic [ADDR_WIDTH:0]                write_addr;
  logic [ADDR_WIDTH-1:0]              wr_rot;
  logic                               ren;
  logic [0:NUM_MG-1][ADDR_WIDTH:0]    read_addr;
  logic                               out_val;
  logic                               out_rdy;
  logic [ADDR_WIDTH-1:0]              out_col;
  logic                               busy;

  modport master (
    input  in_val, out_rdy,
    output in_rdy, wen, write_addr, wr_rot, ren, read_addr, out_val, out_col, busy
  );

  modport slave (
    output in_val, out_rdy,
    input  in_rdy, wen, write_addr, wr_rot, ren, read_addr, out_val, out_col, busy
  );
endinterface

// File: rtl/mtm_skew_addr_gen.sv
// Per-bank skewed read addresses: bank i serves row (i - col) of the requested column.
module mtm_skew_addr_gen
  import mtm_pkg::*;
#(
  parameter int NUM_MG     = 8,
  parameter int NUM_PE     = 8,
  parameter int ADDR_WIDTH = $clog2(NUM_PE)
) (
  input  logic                            rd_buf,
  input  logic [ADDR_WIDTH-1:0]           rd_col,
  output logic [0:NUM_MG-1][ADDR_WIDTH:0] read_addr
);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_MG; gi++) begin : g_bank
      assign read_addr[gi] = {rd_buf, ADDR_WIDTH'(skew_row(gi, 32'(rd_col), NUM_PE))};
    end
  endgenerate

endmodule

// File: rtl/transpose_memory_ctrl.sv
// Ping-pong tile sequencer: row writes into one buffer half while columns drain from the other.
module transpose_memory_ctrl
  import mtm_pkg::*;
#(
  parameter int NUM_MG     = 8,
  parameter int NUM_PE     = 8,
  parameter int ADDR_WIDTH = $clog2(NUM_PE)
) (
  input logic                    clk,
  input logic                    rst,
  transpose_memory_ctrl_if.master bus
);

  localparam int BANK_AW = bank_addr_width(NUM_PE);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_PE - 1);

  logic [1:0]            full_reg, full_next;
  logic                  wr_buf_reg, rd_buf_reg;
  logic [ADDR_WIDTH-1:0] wr_row_reg, rd_col_reg;
  state_t                state_reg;
  logic                  out_val_reg;
  logic [ADDR_WIDTH-1:0] out_col_reg;

  logic in_rdy, wen, wr_last, out_free, ren, rd_last;
  logic [BANK_AW-1:0] write_addr;

  assign in_rdy     = !full_reg[wr_buf_reg] && !rst;
  assign wen        = bus.in_val && in_rdy;
  assign wr_last    = wen && (wr_row_reg == LAST_IDX);
  assign write_addr = {wr_buf_reg, wr_row_reg};

  // Output register can take a new column when empty or being consumed this cycle.
  assign out_free = !out_val_reg || bus.out_rdy;
  assign ren      = (state_reg == DRAIN) ? out_free : (full_reg[rd_buf_reg] && out_free);
  assign rd_last  = ren && (rd_col_reg == LAST_IDX);

  // Set and clear always target different halves, so both may apply together.
  always_comb begin
    full_next = full_reg;
    if (rd_last) full_next[rd_buf_reg] = 1'b0;
    if (wr_last) full_next[wr_buf_reg] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_reg    <= '0;
      wr_buf_reg  <= 1'b0;
      rd_buf_reg  <= 1'b0;
      wr_row_reg  <= '0;
      rd_col_reg  <= '0;
      state_reg   <= IDLE;
      out_val_reg <= 1'b0;
      out_col_reg <= '0;
    end else begin
      full_reg <= full_next;
      if (wen) wr_row_reg <= wr_row_reg + 1'b1;
      if (wr_last) wr_buf_reg <= !wr_buf_reg;
      if (ren) rd_col_reg <= rd_col_reg + 1'b1;
      if (rd_last) rd_buf_reg <= !rd_buf_reg;

      case (state_reg)
        IDLE:    if (full_reg[rd_buf_reg]) state_reg <= DRAIN;
        DRAIN:   if (rd_last) state_reg <= full_reg[!rd_buf_reg] ? DRAIN : IDLE;
        default: state_reg <= IDLE;
      endcase

      if (ren) begin
        out_val_reg <= 1'b1;
        out_col_reg <= rd_col_reg;
      end else if (out_val_reg && bus.out_rdy) begin
        out_val_reg <= 1'b0;
      end
    end
  end

  mtm_skew_addr_gen #(
    .NUM_MG    (NUM_MG),
    .NUM_PE    (NUM_PE),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_skew (
    .rd_buf   (rd_buf_reg),
    .rd_col   (rd_col_reg),
    .read_addr(bus.read_addr)
  );

  assign bus.in_rdy     = in_rdy;
  assign bus.wen        = wen;
  assign bus.write_addr = write_addr;
  assign bus.wr_rot     = wr_row_reg;
  assign bus.ren        = ren;
  assign bus.out_val    = out_val_reg;
  assign bus.out_col    = out_col_reg;
  assign bus.busy       = (|full_reg) || (state_reg == DRAIN);

endmodule

// File: tb/tb_transpose_memory_ctrl.sv
// Directed bench: drives rows, models the skewed banks, and checks control timing and transposed columns.
module tb_transpose_memory_ctrl;

  localparam int NUM_PE = 8;
  localparam int NUM_MG = 8;
  localparam int AW     = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  transpose_memory_ctrl_if #(.NUM_MG(NUM_MG), .NUM_PE(NUM_PE), .ADDR_WIDTH(AW)) bus ();

  transpose_memory_ctrl #(.NUM_MG(NUM_MG), .NUM_PE(NUM_PE), .ADDR_WIDTH(AW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [7:0] tiles [16][8][8];
  logic [7:0] bank [8][16];
  logic [7:0] rd_data [8];
  logic [7:0] rd_next [8];
  int wr_tile, drv_row, rd_tile, exp_col, xfer_cnt;

  logic s_in_rdy, s_wen, s_ren, s_out_val, s_busy;
  logic [3:0] s_waddr;
  logic [2:0] s_wrot, s_out_col;
  logic [0:7][3:0] s_raddr;

  int base, drops, gaps;
  logic started;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    logic [0:7][3:0] ra;
    for (int i = 0; i < 8; i++) ra[i] = 4'(i);
    chk({tag, "_in_rdy"},  64'(bus.in_rdy), 64'(0));
    chk({tag, "_wen"},     64'(bus.wen), 64'(0));
    chk({tag, "_waddr"},   64'(bus.write_addr), 64'(0));
    chk({tag, "_wrot"},    64'(bus.wr_rot), 64'(0));
    chk({tag, "_ren"},     64'(bus.ren), 64'(0));
    chk({tag, "_raddr"},   64'(bus.read_addr), 64'(ra));
    chk({tag, "_out_val"}, 64'(bus.out_val), 64'(0));
    chk({tag, "_out_col"}, 64'(bus.out_col), 64'(0));
    chk({tag, "_busy"},    64'(bus.busy), 64'(0));
  endtask

  // One clock: drive, sample mid-cycle, update bank model, check any column transfer.
  task automatic cyc(input logic iv, input logic ordy);
    logic [63:0] obs_w, exp_w;
    bus.in_val  = iv;
    bus.out_rdy = ordy;
    #1;
    s_in_rdy  = bus.in_rdy;
    s_wen     = bus.wen;
    s_ren     = bus.ren;
    s_out_val = bus.out_val;
    s_busy    = bus.busy;
    s_waddr   = bus.write_addr;
    s_wrot    = bus.wr_rot;
    s_out_col = bus.out_col;
    s_raddr   = bus.read_addr;
    if (bus.wen) begin
      for (int c = 0; c < 8; c++)
        bank[(c + int'(bus.wr_rot)) % 8][bus.write_addr] = tiles[wr_tile % 16][drv_row][c];
      $display("row tile=%0d row=%0d addr=%0h", wr_tile, drv_row, bus.write_addr);
      drv_row++;
      if (drv_row == 8) begin
        drv_row = 0;
        wr_tile++;
      end
    end
    if (bus.ren)
      for (int b = 0; b < 8; b++) rd_next[b] = bank[b][bus.read_addr[b]];
    if (bus.out_val && bus.out_rdy) begin
      for (int j = 0; j < 8; j++) begin
        obs_w[j*8 +: 8] = rd_data[(j + int'(bus.out_col)) % 8];
        exp_w[j*8 +: 8] = tiles[rd_tile % 16][j][exp_col];
      end
      $display("col tile=%0d col=%0d data=%h", rd_tile, bus.out_col, obs_w);
      chk("out_col", 64'(bus.out_col), 64'(exp_col));
      chk("col_data", obs_w, exp_w);
      xfer_cnt++;
      exp_col++;
      if (exp_col == 8) begin
        exp_col = 0;
        rd_tile++;
      end
    end
    @(posedge clk);
    #1;
    if (s_ren) rd_data = rd_next;
  endtask

  task automatic track_gap();
    if (s_out_val) started = 1'b1;
    if (started && !s_out_val && (xfer_cnt - base) < 24) gaps++;
  endtask

  initial begin
    rst = 1'b1;
    bus.in_val  = 1'b0;
    bus.out_rdy = 1'b0;
    wr_tile = 0; drv_row = 0; rd_tile = 0; exp_col = 0; xfer_cnt = 0;
    for (int t = 0; t < 16; t++)
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++) tiles[t][r][c] = 8'($urandom);

    // Power-on reset values
    repeat (2) @(posedge clk);
    #1;
    chk_reset("por");
    rst = 1'b0;
    cyc(1'b0, 1'b0);
    chk("in_rdy_after_rst", 64'(s_in_rdy), 64'(1));

    // One tile, back-to-back rows, free-flowing output
    for (int r = 0; r < 8; r++) begin
      cyc(1'b1, 1'b1);
      chk("t1_wen", 64'(s_wen), 64'(1));
      chk("t1_waddr", 64'(s_waddr), 64'(r));
      chk("t1_wrot", 64'(s_wrot), 64'(r));
    end
    for (int j = 0; j < 10; j++) begin
      cyc(1'b0, 1'b1);
      chk("t1_ren", 64'(s_ren), 64'(j < 8));
      chk("t1_out_val", 64'(s_out_val), 64'(j >= 1 && j <= 8));
      if (j == 5) chk("t1_raddr3_k5", 64'(s_raddr[3]), 64'(6));
    end
    chk("t1_xfers", 64'(xfer_cnt), 64'(8));
    chk("t1_busy_idle", 64'(s_busy), 64'(0));

    // Three tiles streamed continuously
    base = xfer_cnt; drops = 0; gaps = 0; started = 1'b0;
    for (int n = 0; n < 24; n++) begin
      cyc(1'b1, 1'b1);
      if (!s_in_rdy) drops++;
      if (n % 8 == 0) chk("t2_waddr_half", 64'(s_waddr), 64'(((n / 8 + 1) % 2) * 8));
      track_gap();
    end
    for (int n = 0; n < 12; n++) begin
      cyc(1'b0, 1'b1);
      track_gap();
    end
    chk("t2_in_rdy_drops", 64'(drops), 64'(0));
    chk("t2_out_gaps", 64'(gaps), 64'(0));
    chk("t2_xfers", 64'(xfer_cnt - base), 64'(24));

    // Output stall held at column 4
    base = xfer_cnt;
    for (int r = 0; r < 8; r++) cyc(1'b1, 1'b1);
    repeat (5) cyc(1'b0, 1'b1);
    for (int s = 0; s < 10; s++) begin
      cyc(1'b0, 1'b0);
      chk("t3_hold_val", 64'(s_out_val), 64'(1));
      chk("t3_hold_col", 64'(s_out_col), 64'(4));
      chk("t3_hold_ren", 64'(s_ren), 64'(0));
    end
    repeat (6) cyc(1'b0, 1'b1);
    chk("t3_xfers", 64'(xfer_cnt - base), 64'(8));
    chk("t3_out_val_done", 64'(s_out_val), 64'(0));

    // Both halves full, then release
    base = xfer_cnt; drops = 0;
    for (int n = 0; n < 16; n++) begin
      cyc(1'b1, 1'b0);
      if (!s_in_rdy) drops++;
    end
    chk("t4_fill_drops", 64'(drops), 64'(0));
    for (int n = 0; n < 3; n++) begin
      cyc(1'b1, 1'b0);
      chk("t4_full_in_rdy", 64'(s_in_rdy), 64'(0));
      chk("t4_full_wen", 64'(s_wen), 64'(0));
    end
    chk("t4_busy", 64'(s_busy), 64'(1));
    for (int m = 0; m < 8; m++) begin
      cyc(1'b0, 1'b1);
      chk("t4_in_rdy_return", 64'(s_in_rdy), 64'(m == 7));
      if (m == 6) chk("t4_ren_last", 64'(s_ren), 64'(1));
    end
    repeat (12) cyc(1'b0, 1'b1);
    chk("t4_xfers", 64'(xfer_cnt - base), 64'(16));

    // Reset mid-tile and mid-drain
    for (int r = 0; r < 13; r++) cyc(1'b1, 1'b1);
    rst = 1'b1;
    #1;
    chk_reset("mid");
    @(posedge clk);
    #1;
    chk_reset("mid_hold");
    rst = 1'b0;
    drv_row = 0;
    wr_tile++;
    rd_tile = wr_tile;
    exp_col = 0;
    base = xfer_cnt;
    for (int r = 0; r < 8; r++) begin
      cyc(1'b1, 1'b1);
      chk("t5_waddr", 64'(s_waddr), 64'(r));
    end
    repeat (10) cyc(1'b0, 1'b1);
    chk("t5_xfers", 64'(xfer_cnt - base), 64'(8));

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
